axi_pmu_ctrl: RTL and testbench

Measurement controller for the AXI PMU counter bank. It accepts opcodes on a valid/ready command port and drives the bank's count-enable (pmu_en) and synchronous clear (pmu_clr). It runs free-running or fixed-length measurement windows, snapshots the flattened counter vector into shadow registers, and streams the snapshot out as OUT_W-bit words on a valid/ready dump port. It sits between the host/debug access logic and one axi_pmu instance.

---
 rtl/axi_pmu_pkg.sv | 37 +++
 rtl/pmu_dump_serializer.sv | 76 +++++++
 rtl/axi_pmu_ctrl.sv | 147 ++++++++++++++
 tb/tb_axi_pmu_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pmu_pkg.sv
// Shared types and constants for the AXI PMU counter bank and its controller.
// Counter ordering: read-channel counters first, then write-channel counters.
package axi_pmu_pkg;

    localparam int PMU_NUM_RD_CNT = 7;
    localparam int PMU_NUM_WR_CNT = 11;
    localparam int PMU_NUM_CNT    = PMU_NUM_RD_CNT + PMU_NUM_WR_CNT;
    localparam int PMU_CNT_W      = 64;
    localparam int PMU_OUT_W      = 32;
    localparam int PMU_WIN_W      = 32;

    localparam int PMU_RD_BASE    = 0;
    localparam int PMU_WR_BASE    = PMU_RD_BASE + PMU_NUM_RD_CNT;

    typedef enum logic [2:0] {
        OP_NOP      = 3'd0,
        OP_CLEAR    = 3'd1,
        OP_START    = 3'd2,
        OP_STOP     = 3'd3,
        OP_WINDOW   = 3'd4,
        OP_SNAPSHOT = 3'd5,
        OP_DUMP     = 3'd6,
        OP_RSVD     = 3'd7
    } pmu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_WINDOW = 2'd2,
        ST_DUMP   = 2'd3
    } pmu_ctrl_state_e;

    function automatic logic pmu_counting(input pmu_ctrl_state_e s);
        return (s == ST_RUN) || (s == ST_WINDOW);
    endfunction

endpackage

// File: rtl/pmu_dump_serializer.sv
// Shadow copy of the counter vector, streamed out as OUT_W-bit words
// (counter 0 first, low word first) over a valid/ready port.
module pmu_dump_serializer
    import axi_pmu_pkg::*;
#(
    parameter int NUM_CNT = PMU_NUM_CNT,
    parameter int CNT_W   = PMU_CNT_W,
    parameter int OUT_W   = PMU_OUT_W
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic [NUM_CNT*CNT_W-1:0] i_cnt,
    input  logic                     i_cap,
    input  logic                     i_start,
    output logic                     o_done,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [OUT_W-1:0]         o_data,
    output logic                     o_last
);

    localparam int TOT_W  = NUM_CNT * CNT_W;
    localparam int NWORDS = TOT_W / OUT_W;
    localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

    logic [TOT_W-1:0] r_shadow;
    logic [IDX_W-1:0] r_idx;
    logic             r_valid;
    logic             r_last;
    logic [OUT_W-1:0] r_data;

    logic             w_hs;
    logic [IDX_W-1:0] w_idx_nxt;
    logic [OUT_W-1:0] w_word_nxt;

    assign w_hs       = r_valid && i_ready;
    assign w_idx_nxt  = r_idx + IDX_W'(1);
    assign w_word_nxt = r_shadow[int'(w_idx_nxt)*OUT_W +: OUT_W];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_shadow <= '0;
            r_idx    <= '0;
            r_valid  <= 1'b0;
            r_last   <= 1'b0;
            r_data   <= '0;
        end else begin
            if (i_start || i_cap)
                r_shadow <= i_cnt;
            // word 0 comes straight from the live vector on the capture edge
            if (i_start) begin
                r_idx   <= '0;
                r_valid <= 1'b1;
                r_data  <= i_cnt[OUT_W-1:0];
                r_last  <= (NWORDS == 1);
            end else if (w_hs) begin
                if (r_idx == LAST_IDX) begin
                    r_idx   <= '0;
                    r_valid <= 1'b0;
                    r_last  <= 1'b0;
                end else begin
                    r_idx  <= w_idx_nxt;
                    r_data <= w_word_nxt;
                    r_last <= (w_idx_nxt == LAST_IDX);
                end
            end
        end
    end

    assign o_done  = w_hs && r_last;
    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_last  = r_last;

endmodule

// File: rtl/axi_pmu_ctrl.sv
// Measurement controller for the AXI PMU counter bank: run/window control,
// clear pulses, snapshots and the shadow dump stream.
module axi_pmu_ctrl
    import axi_pmu_pkg::*;
#(
    parameter int NUM_CNT = PMU_NUM_CNT,
    parameter int CNT_W   = PMU_CNT_W,
    parameter int OUT_W   = PMU_OUT_W,
    parameter int WIN_W   = PMU_WIN_W
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [2:0]               cmd_op,
    input  logic [WIN_W-1:0]         cmd_arg,
    output logic                     pmu_en,
    output logic                     pmu_clr,
    input  logic [NUM_CNT*CNT_W-1:0] cnt_in,
    output logic                     dump_valid,
    input  logic                     dump_ready,
    output logic [OUT_W-1:0]         dump_data,
    output logic                     dump_last,
    output logic                     busy,
    output logic                     window_done
);

    pmu_ctrl_state_e r_state, w_nxt;
    logic [WIN_W-1:0] r_rem, w_rem_nxt;
    logic             r_pmu_en, r_pmu_clr, r_busy, r_win_done, r_exp_snap;

    logic    w_acc, w_clr, w_snap, w_start, w_wdone, w_expire, w_ser_done;
    pmu_op_e w_op;

    assign cmd_ready = aresetn && (r_state != ST_DUMP);
    assign w_acc     = cmd_valid && cmd_ready;
    assign w_op      = pmu_op_e'(cmd_op);

    always_comb begin
        w_nxt     = r_state;
        w_rem_nxt = r_rem;
        w_clr     = 1'b0;
        w_snap    = 1'b0;
        w_start   = 1'b0;
        w_wdone   = 1'b0;
        w_expire  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_acc) begin
                    case (w_op)
                        OP_START:    w_nxt = ST_RUN;
                        OP_CLEAR:    w_clr = 1'b1;
                        OP_SNAPSHOT: w_snap = 1'b1;
                        OP_DUMP: begin
                            w_nxt   = ST_DUMP;
                            w_start = 1'b1;
                        end
                        OP_WINDOW: begin
                            if (cmd_arg != '0) begin
                                w_nxt     = ST_WINDOW;
                                w_rem_nxt = cmd_arg;
                            end else begin
                                w_wdone = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                if (w_acc) begin
                    case (w_op)
                        OP_STOP:     w_nxt = ST_IDLE;
                        OP_CLEAR:    w_clr = 1'b1;
                        OP_SNAPSHOT: w_snap = 1'b1;
                        default: ;
                    endcase
                end
            end
            ST_WINDOW: begin
                w_rem_nxt = r_rem - WIN_W'(1);
                // expiry wins over a coincident STOP
                if (r_rem == WIN_W'(1)) begin
                    w_nxt    = ST_IDLE;
                    w_wdone  = 1'b1;
                    w_expire = 1'b1;
                end else if (w_acc && w_op == OP_STOP) begin
                    w_nxt     = ST_IDLE;
                    w_rem_nxt = '0;
                end
                if (w_acc && w_op == OP_CLEAR)
                    w_clr = 1'b1;
                if (w_acc && w_op == OP_SNAPSHOT)
                    w_snap = 1'b1;
            end
            ST_DUMP: begin
                if (w_ser_done)
                    w_nxt = ST_IDLE;
            end
            default: w_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state    <= ST_IDLE;
            r_rem      <= '0;
            r_pmu_en   <= 1'b0;
            r_pmu_clr  <= 1'b0;
            r_busy     <= 1'b0;
            r_win_done <= 1'b0;
            r_exp_snap <= 1'b0;
        end else begin
            r_state    <= w_nxt;
            r_rem      <= w_rem_nxt;
            r_pmu_en   <= pmu_counting(w_nxt);
            r_pmu_clr  <= w_clr;
            r_busy     <= (w_nxt != ST_IDLE);
            r_win_done <= w_wdone;
            r_exp_snap <= w_expire;
        end
    end

    // the post-expiry capture sees the bank's final increment
    pmu_dump_serializer #(
        .NUM_CNT (NUM_CNT),
        .CNT_W   (CNT_W),
        .OUT_W   (OUT_W)
    ) u_ser (
        .aclk    (aclk),
        .aresetn (aresetn),
        .i_cnt   (cnt_in),
        .i_cap   (w_snap || r_exp_snap),
        .i_start (w_start),
        .o_done  (w_ser_done),
        .o_valid (dump_valid),
        .i_ready (dump_ready),
        .o_data  (dump_data),
        .o_last  (dump_last)
    );

    assign pmu_en      = r_pmu_en;
    assign pmu_clr     = r_pmu_clr;
    assign busy        = r_busy;
    assign window_done = r_win_done;

endmodule

// File: tb/tb_axi_pmu_ctrl.sv
// Directed bench for axi_pmu_ctrl: windows, run/clear/stop, dumps with
// back-pressure and reset in the middle of a dump.
module tb_axi_pmu_ctrl;
    import axi_pmu_pkg::*;

    localparam int NC = 18;
    localparam int CW = 64;
    localparam int OW = 32;
    localparam int WW = 32;
    localparam int NW = NC * CW / OW;

    logic              aclk = 1'b0;
    logic              aresetn = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [2:0]        cmd_op = 3'd0;
    logic [WW-1:0]     cmd_arg = '0;
    logic              pmu_en, pmu_clr;
    logic [NC*CW-1:0]  cnt_in = '0;
    logic              dump_valid;
    logic              dump_ready = 1'b0;
    logic [OW-1:0]     dump_data;
    logic              dump_last, busy, window_done;

    int  n_chk = 0;
    int  n_err = 0;
    bit  auto_cnt = 1'b0;

    always #5 aclk = ~aclk;

    always @(posedge aclk) begin
        #2;
        if (auto_cnt)
            cnt_in[63:0] = cnt_in[63:0] + 64'd1;
    end

    axi_pmu_ctrl #(
        .NUM_CNT (NC),
        .CNT_W   (CW),
        .OUT_W   (OW),
        .WIN_W   (WW)
    ) u_dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_arg     (cmd_arg),
        .pmu_en      (pmu_en),
        .pmu_clr     (pmu_clr),
        .cnt_in      (cnt_in),
        .dump_valid  (dump_valid),
        .dump_ready  (dump_ready),
        .dump_data   (dump_data),
        .dump_last   (dump_last),
        .busy        (busy),
        .window_done (window_done)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // drive at a negedge, accepted on the next posedge, returns one negedge later
    task automatic send(input pmu_op_e op, input logic [WW-1:0] arg);
        int n = 0;
        while (!cmd_ready && n < 100) begin
            @(negedge aclk);
            n++;
        end
        if (n >= 100)
            chk("send_ready_timeout", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        @(negedge aclk);
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_arg   = '0;
    endtask

    task automatic set_pat(input logic [31:0] lo, input logic [31:0] hi);
        for (int k = 0; k < NC; k++)
            cnt_in[k*CW +: CW] = {hi + 32'(k), lo + 32'(k)};
    endtask

    task automatic do_dump(input bit tog, input logic [31:0] lo,
                           input logic [31:0] hi);
        int          w = 0;
        int          j = 0;
        bit          done = 1'b0;
        bit          stalled = 1'b0;
        bit          rdy_hi = 1'b0;
        logic [31:0] pd = '0;
        logic        pl = 1'b0;
        logic [31:0] ev;
        set_pat(lo, hi);
        send(OP_DUMP, '0);
        cnt_in = '1;
        chk("dump_first_valid", 64'(dump_valid), 64'd1);
        while (!done && j < 300) begin
            if (cmd_ready)
                rdy_hi = 1'b1;
            if (stalled) begin
                chk("dump_hold_data", 64'(dump_data), 64'(pd));
                chk("dump_hold_last", 64'(dump_last), 64'(pl));
            end
            dump_ready = tog ? (j % 2 == 0) : 1'b1;
            if (dump_valid && dump_ready) begin
                ev = (w % 2 == 0) ? lo + 32'(w / 2) : hi + 32'(w / 2);
                chk($sformatf("dump_word%0d", w), 64'(dump_data), 64'(ev));
                chk($sformatf("dump_last%0d", w), 64'(dump_last),
                    64'(w == NW - 1));
                if (w == NW - 1)
                    done = 1'b1;
                w++;
            end
            stalled = dump_valid && !dump_ready;
            pd = dump_data;
            pl = dump_last;
            j++;
            @(negedge aclk);
        end
        dump_ready = 1'b0;
        chk("dump_word_count", 64'(w), 64'(NW));
        chk("dump_cmd_ready_low", 64'(rdy_hi), 64'd0);
        chk("dump_end_valid", 64'(dump_valid), 64'd0);
        chk("dump_end_cmd_ready", 64'(cmd_ready), 64'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          c_en, c_busy, c_wd, wd_at, c_clr;
        logic [63:0] snap;
        bit          sh_ok;

        // reset values
        #3;
        chk("rst_pmu_en", 64'(pmu_en), 64'd0);
        chk("rst_pmu_clr", 64'(pmu_clr), 64'd0);
        chk("rst_dump_valid", 64'(dump_valid), 64'd0);
        chk("rst_dump_last", 64'(dump_last), 64'd0);
        chk("rst_dump_data", 64'(dump_data), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_window_done", 64'(window_done), 64'd0);
        chk("rst_shadow", 64'(u_dut.u_ser.r_shadow[63:0]), 64'd0);
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);

        // reserved opcode is a no-op
        send(OP_RSVD, 32'd5);
        chk("rsvd_busy", 64'(busy), 64'd0);
        chk("rsvd_pmu_en", 64'(pmu_en), 64'd0);

        // WINDOW 100
        auto_cnt = 1'b1;
        send(OP_WINDOW, 32'd100);
        c_en = 0; c_busy = 0; c_wd = 0; wd_at = -1; snap = '0;
        for (int i = 0; i < 110; i++) begin
            if (pmu_en) c_en++;
            if (busy) c_busy++;
            if (window_done) begin
                c_wd++;
                wd_at = i;
                snap = cnt_in[63:0];
            end
            if (i == 101)
                chk("win_shadow", u_dut.u_ser.r_shadow[63:0], snap);
            @(negedge aclk);
        end
        auto_cnt = 1'b0;
        chk("win_en_cycles", 64'(c_en), 64'd100);
        chk("win_busy_cycles", 64'(c_busy), 64'd100);
        chk("win_done_pulses", 64'(c_wd), 64'd1);
        chk("win_done_cycle", 64'(wd_at), 64'd100);

        // dump with 1010 back-pressure
        do_dump(1'b1, 32'h0000_0000, 32'h0000_1000);

        // SNAPSHOT, then WINDOW 100 aborted at elapsed cycle 40
        cnt_in[63:0] = 64'hABCD;
        send(OP_SNAPSHOT, '0);
        chk("snap_shadow", u_dut.u_ser.r_shadow[63:0], 64'hABCD);
        auto_cnt = 1'b1;
        send(OP_WINDOW, 32'd100);
        repeat (39) @(negedge aclk);
        chk("abort_en_before", 64'(pmu_en), 64'd1);
        send(OP_STOP, '0);
        chk("abort_en_after", 64'(pmu_en), 64'd0);
        chk("abort_busy_after", 64'(busy), 64'd0);
        c_wd = 0;
        for (int i = 0; i < 120; i++) begin
            if (window_done) c_wd++;
            @(negedge aclk);
        end
        auto_cnt = 1'b0;
        chk("abort_no_done", 64'(c_wd), 64'd0);
        chk("abort_shadow", u_dut.u_ser.r_shadow[63:0], 64'hABCD);

        // START, CLEAR after 20 cycles, STOP
        send(OP_START, '0);
        chk("run_en", 64'(pmu_en), 64'd1);
        repeat (19) @(negedge aclk);
        send(OP_CLEAR, '0);
        c_clr = 0; c_en = 0;
        for (int i = 0; i < 10; i++) begin
            if (pmu_clr) c_clr++;
            if (pmu_en) c_en++;
            @(negedge aclk);
        end
        chk("run_clr_pulses", 64'(c_clr), 64'd1);
        chk("run_en_held", 64'(c_en), 64'd10);
        send(OP_STOP, '0);
        chk("run_stop_en", 64'(pmu_en), 64'd0);
        chk("run_stop_busy", 64'(busy), 64'd0);

        // reset after word 10's handshake
        set_pat(32'h0, 32'h1000);
        send(OP_DUMP, '0);
        dump_ready = 1'b1;
        repeat (11) @(negedge aclk);
        aresetn = 1'b0;
        #1;
        chk("mrst_dump_valid", 64'(dump_valid), 64'd0);
        chk("mrst_dump_data", 64'(dump_data), 64'd0);
        chk("mrst_dump_last", 64'(dump_last), 64'd0);
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_pmu_en", 64'(pmu_en), 64'd0);
        chk("mrst_cmd_ready", 64'(cmd_ready), 64'd0);
        dump_ready = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        chk("mrst_cmd_ready_rel", 64'(cmd_ready), 64'd1);
        do_dump(1'b0, 32'h0000_0100, 32'h0000_2000);

        // WINDOW 0: no enable, done next cycle, shadow untouched
        cnt_in[63:0] = 64'h5555;
        send(OP_WINDOW, '0);
        chk("w0_done", 64'(window_done), 64'd1);
        chk("w0_en", 64'(pmu_en), 64'd0);
        chk("w0_busy", 64'(busy), 64'd0);
        c_en = 0; c_wd = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            if (pmu_en || busy) c_en++;
            if (window_done) c_wd++;
        end
        chk("w0_en_never", 64'(c_en), 64'd0);
        chk("w0_single_pulse", 64'(c_wd), 64'd0);
        chk("w0_shadow", u_dut.u_ser.r_shadow[63:0], 64'h0000_2000_0000_0100);

        // WINDOW 1
        auto_cnt = 1'b1;
        send(OP_WINDOW, 32'd1);
        chk("w1_en", 64'(pmu_en), 64'd1);
        chk("w1_busy", 64'(busy), 64'd1);
        @(negedge aclk);
        chk("w1_en_off", 64'(pmu_en), 64'd0);
        chk("w1_done", 64'(window_done), 64'd1);
        snap = cnt_in[63:0];
        @(negedge aclk);
        auto_cnt = 1'b0;
        chk("w1_done_off", 64'(window_done), 64'd0);
        chk("w1_shadow", u_dut.u_ser.r_shadow[63:0], snap);
        sh_ok = (cnt_in[63:0] != snap);
        chk("w1_cnt_moved", 64'(sh_ok), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
